// File: rtl/gesture_pose_sequencer.sv
// Gesture pose sequencer. Debounces the finger-count gesture stream, looks up
// a target pose in a host-writable pose table and slew-limits every servo
// channel toward it at one degree per STEP_DIV cycles.
//
// Optional feature macro: GESTURE_TIMEOUT_EN. When defined, TIMEOUT_CYCLES
// consecutive cycles without gesture_valid force target_pose back to the
// rest pose 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   finger_count    detected finger count, qualified by gesture_valid
//   gesture_valid   one sample per asserted cycle
//   cfg_we          pose table write strobe (cfg_pose, cfg_servo, cfg_angle)
//   servo_angle     current angles, channel i at [i*ANGLE_W +: ANGLE_W]
//   target_pose     committed pose index
//   busy            high while moving
//   pose_reached    one-cycle pulse when all channels reach the target
module gesture_pose_sequencer #(
  parameter int unsigned NUM_SERVOS     = 4,
  parameter int unsigned ANGLE_W        = 8,
  parameter int unsigned NUM_POSES      = 8,
  parameter int unsigned MAX_ANGLE      = 180,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned STEP_DIV       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned PoseW  = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1,
  localparam int unsigned ServoW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    finger_count,
  input  logic                          gesture_valid,
  input  logic                          cfg_we,
  input  logic [PoseW-1:0]              cfg_pose,
  input  logic [ServoW-1:0]             cfg_servo,
  input  logic [ANGLE_W-1:0]            cfg_angle,
  output logic [NUM_SERVOS*ANGLE_W-1:0] servo_angle,
  output logic [PoseW-1:0]              target_pose,
  output logic                          busy,
  output logic                          pose_reached
);

  localparam int unsigned CntW  = $clog2(STABLE_COUNT + 1);
  localparam int unsigned TickW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [ANGLE_W-1:0] MaxAngle  = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] RestAngle = ANGLE_W'(90);
  localparam logic [CntW-1:0]    StableMax = CntW'(STABLE_COUNT);
  localparam logic [TickW-1:0]   TickLast  = TickW'(STEP_DIV - 1);

  if (STABLE_COUNT < 1 || STEP_DIV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("gesture_pose_sequencer: STABLE_COUNT, STEP_DIV, TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {StIdle, StMove} state_e;

  state_e state_q, state_d;

  logic [ANGLE_W-1:0] table_q [NUM_POSES][NUM_SERVOS];
  logic [ANGLE_W-1:0] angle_q [NUM_SERVOS];
  logic [ANGLE_W-1:0] angle_d [NUM_SERVOS];
  logic [ANGLE_W-1:0] goal    [NUM_SERVOS];
  logic               all_match;

  logic [TickW-1:0] tick_q, tick_d;
  logic [PoseW-1:0] cand_q, cand_d, target_q, target_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pose_reached_q, pose_reached_d;

  // Pose table: out-of-range addresses are dropped, angles clamp to MaxAngle.
  logic               cfg_hit;
  logic [ANGLE_W-1:0] cfg_clamped;
  assign cfg_hit     = cfg_we && (32'(cfg_pose) < NUM_POSES) && (32'(cfg_servo) < NUM_SERVOS);
  assign cfg_clamped = (cfg_angle > MaxAngle) ? MaxAngle : cfg_angle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < int'(NUM_POSES); p++) begin
        for (int s = 0; s < int'(NUM_SERVOS); s++) begin
          table_q[p][s] <= RestAngle;
        end
      end
    end else if (cfg_hit) begin
      table_q[cfg_pose][cfg_servo] <= cfg_clamped;
    end
  end

  // Goal reads the pre-write table, so a same-cycle write affects the next step.
  always_comb begin
    all_match = 1'b1;
    for (int i = 0; i < int'(NUM_SERVOS); i++) begin
      goal[i] = table_q[target_q][i];
      if (angle_q[i] != goal[i]) all_match = 1'b0;
    end
  end

  // Debounce: candidate plus saturating run-length counter.
  logic             sample_ok;
  logic [PoseW-1:0] sample_idx;
  assign sample_ok  = gesture_valid && (32'(finger_count) < NUM_POSES);
  assign sample_idx = PoseW'(finger_count);

`ifdef GESTURE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (sample_ok) begin
      if (sample_idx == cand_q) begin
        if (cnt_q != StableMax) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = sample_idx;
        cnt_d  = CntW'(1);
      end
      // Commit on the edge the run length is reached; no extra stage.
      if (cnt_d == StableMax) target_d = cand_d;
    end
`ifdef GESTURE_TIMEOUT_EN
    tmo_d = gesture_valid ? '0 : tmo_q + 1'b1;
    if (!gesture_valid && tmo_q == TmoLast) begin
      target_d = '0;
      cand_d   = '0;
      cnt_d    = '0;
      tmo_d    = '0;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!all_match) state_d = StMove;
      StMove:  if (all_match)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and slew datapath. The tick counter only runs while moving, so
  // a retarget mid-move keeps the step cadence.
  always_comb begin
    busy           = (state_q == StMove);
    pose_reached_d = (state_q == StMove) && all_match;
    tick_d         = '0;
    for (int i = 0; i < int'(NUM_SERVOS); i++) angle_d[i] = angle_q[i];
    if (state_q == StMove && !all_match) begin
      tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
      if (tick_q == TickLast) begin
        for (int i = 0; i < int'(NUM_SERVOS); i++) begin
          if (angle_q[i] < goal[i])      angle_d[i] = angle_q[i] + 1'b1;
          else if (angle_q[i] > goal[i]) angle_d[i] = angle_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SERVOS); i++) angle_q[i] <= RestAngle;
      tick_q         <= '0;
      cand_q         <= '0;
      cnt_q          <= '0;
      target_q       <= '0;
      pose_reached_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SERVOS); i++) angle_q[i] <= angle_d[i];
      tick_q         <= tick_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      pose_reached_q <= pose_reached_d;
    end
  end

`ifdef GESTURE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    for (int i = 0; i < int'(NUM_SERVOS); i++) begin
      servo_angle[i*ANGLE_W +: ANGLE_W] = angle_q[i];
    end
  end

  assign target_pose  = target_q;
  assign pose_reached = pose_reached_q;

endmodule

// File: tb/tb_gesture_pose_sequencer.sv
// Self-checking bench for gesture_pose_sequencer (default build). A reference
// model tracks table, debounce history and motion every cycle; directed
// sequences and a debounce vector table add constant expectations.
module tb_gesture_pose_sequencer;
  localparam int NS = 4, AW = 8, NP = 8, MAXA = 180, SC = 3, SD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      finger_count = '0;
  logic            gesture_valid = 1'b0;
  logic            cfg_we = 1'b0;
  logic [2:0]      cfg_pose = '0;
  logic [1:0]      cfg_servo = '0;
  logic [AW-1:0]   cfg_angle = '0;
  logic [NS*AW-1:0] servo_angle;
  logic [2:0]      target_pose;
  logic            busy;
  logic            pose_reached;

  always #5 clk = ~clk;

  gesture_pose_sequencer #(
    .NUM_SERVOS(NS), .ANGLE_W(AW), .NUM_POSES(NP), .MAX_ANGLE(MAXA),
    .STABLE_COUNT(SC), .STEP_DIV(SD), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .finger_count(finger_count), .gesture_valid(gesture_valid),
    .cfg_we(cfg_we), .cfg_pose(cfg_pose), .cfg_servo(cfg_servo), .cfg_angle(cfg_angle),
    .servo_angle(servo_angle), .target_pose(target_pose), .busy(busy),
    .pose_reached(pose_reached)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain arrays, a sample history queue and a move phase.
  int m_tab[NP][NS];
  int m_ang[NS];
  int m_tgt;
  bit m_moving;
  int m_phase;
  bit m_pulse;
  int hist[$];
  int jumps;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) for (int s = 0; s < NS; s++) m_tab[p][s] = 90;
    for (int i = 0; i < NS; i++) m_ang[i] = 90;
    m_tgt = 0; m_moving = 0; m_phase = 0; m_pulse = 0;
    hist.delete();
  endtask

  task automatic model_step();
    int  goal[NS];
    bit  eq;
    int  fc, a;
    eq = 1;
    for (int i = 0; i < NS; i++) begin
      goal[i] = m_tab[m_tgt][i];
      if (m_ang[i] != goal[i]) eq = 0;
    end
    m_pulse = 0;
    if (!m_moving) begin
      if (!eq) begin m_moving = 1; m_phase = 0; end
    end else if (eq) begin
      m_moving = 0; m_pulse = 1;
    end else begin
      if (m_phase % SD == SD - 1)
        for (int i = 0; i < NS; i++)
          m_ang[i] += (m_ang[i] < goal[i]) ? 1 : (m_ang[i] > goal[i]) ? -1 : 0;
      m_phase++;
    end
    if (cfg_we) begin
      a = 32'(cfg_angle);
      m_tab[32'(cfg_pose)][32'(cfg_servo)] = (a > MAXA) ? MAXA : a;
    end
    fc = 32'(finger_count);
    if (gesture_valid && fc < NP) begin
      hist.push_back(fc);
      if (hist.size() > SC) void'(hist.pop_front());
      if (hist.size() == SC && hist.min() == hist.max()) m_tgt = fc;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NS; i++) chk("servo_angle", 32'(servo_angle[i*AW +: AW]), m_ang[i]);
    chk("target_pose", 32'(target_pose), m_tgt);
    chk("busy", 32'(busy), 32'(m_moving));
    chk("pose_reached", 32'(pose_reached), 32'(m_pulse));
  endtask

  task automatic tick();
    int prev[NS];
    int d;
    for (int i = 0; i < NS; i++) prev[i] = 32'(servo_angle[i*AW +: AW]);
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NS; i++) begin
      d = 32'(servo_angle[i*AW +: AW]) - prev[i];
      if (d > 1 || d < -1) jumps++;
    end
    compare();
  endtask

  task automatic write_cfg(input int p, input int s, input int a);
    cfg_we = 1'b1; cfg_pose = 3'(p); cfg_servo = 2'(s); cfg_angle = 8'(a);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sample(input int fc, input int n);
    for (int k = 0; k < n; k++) begin
      gesture_valid = 1'b1; finger_count = 4'(fc);
      tick();
    end
    gesture_valid = 1'b0;
  endtask

  task automatic run_until_reached(input int bound, output int n);
    n = 0;
    while (pose_reached !== 1'b1 && n < bound) begin tick(); n++; end
    chk("reach_within_bound", 32'(pose_reached), 1);
  endtask

  typedef struct {
    logic       valid;
    logic [3:0] fc;
    logic [2:0] exp_tgt;
  } vec_t;

  vec_t vecs[8];
  int n, pulses, busy_drop, intent;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 2,2,3,2,(9),2,(9),2: only the last sample completes a run of three.
    vecs[0] = '{1'b1, 4'd2, 3'd0}; vecs[1] = '{1'b1, 4'd2, 3'd0};
    vecs[2] = '{1'b1, 4'd3, 3'd0}; vecs[3] = '{1'b1, 4'd2, 3'd0};
    vecs[4] = '{1'b1, 4'd9, 3'd0}; vecs[5] = '{1'b1, 4'd2, 3'd0};
    vecs[6] = '{1'b1, 4'd9, 3'd0}; vecs[7] = '{1'b1, 4'd2, 3'd2};
    jumps = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (100) tick();
    chk("rest_angles", 32'(servo_angle), {4{8'd90}});
    chk("rest_target", 32'(target_pose), 0);

    // Pose 2 and the debounce vector table.
    write_cfg(2, 1, 120);
    write_cfg(2, 2, 60);
    foreach (vecs[k]) begin
      gesture_valid = vecs[k].valid; finger_count = vecs[k].fc;
      tick();
      chk("debounce_vec", 32'(target_pose), 32'(vecs[k].exp_tgt));
    end
    gesture_valid = 1'b0;
    run_until_reached(2000, n);
    chk("move_cycles", n, 30 * SD + 2);
    chk("pose2_servo1", 32'(servo_angle[15:8]), 120);
    chk("pose2_servo2", 32'(servo_angle[23:16]), 60);
    pulses = 0;
    repeat (60) begin tick(); if (pose_reached === 1'b1) pulses++; end
    chk("single_pulse", pulses, 0);

    // Retarget mid-move: back to 0, out to 2, then switch to 5 part way.
    write_cfg(5, 1, 135);
    write_cfg(5, 2, 135);
    write_cfg(5, 3, 0);
    sample(0, 3);
    run_until_reached(2000, n);
    sample(2, 3);
    chk("commit_third", 32'(target_pose), 2);
    repeat (200) tick();
    chk("busy_midmove", 32'(busy), 1);
    jumps = 0;
    sample(5, 3);
    chk("retarget", 32'(target_pose), 5);
    n = 0; busy_drop = 0;
    while (pose_reached !== 1'b1 && n < 4000) begin
      if (busy !== 1'b1) busy_drop++;
      tick(); n++;
    end
    chk("retarget_reached", 32'(pose_reached), 1);
    chk("busy_held", busy_drop, 0);
    chk("no_jumps", jumps, 0);
    chk("pose5_angles", 32'(servo_angle), {8'd0, 8'd135, 8'd135, 8'd90});

    // Clamp: 200 written, 180 stored.
    write_cfg(1, 0, 200);
    sample(1, 3);
    run_until_reached(3000, n);
    chk("clamp_servo0", 32'(servo_angle[7:0]), 180);

    // Asynchronous reset in the middle of a move.
    sample(2, 3);
    repeat (100) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_angles", 32'(servo_angle), {4{8'd90}});
    chk("arst_target", 32'(target_pose), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pulse", 32'(pose_reached), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();

    // Randomised traffic against the model.
    intent = 2;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) intent = int'($urandom_range(0, 11));
      gesture_valid = ($urandom_range(0, 3) != 0);
      finger_count  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(intent);
      cfg_we    = ($urandom_range(0, 49) == 0);
      cfg_pose  = 3'($urandom_range(0, 7));
      cfg_servo = 2'($urandom_range(0, 3));
      cfg_angle = 8'($urandom_range(0, 255));
      tick();
    end
    cfg_we = 1'b0; gesture_valid = 1'b0;
    chk("random_no_jumps", jumps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gesture_pose_sequencer.md
Name: gesture_pose_sequencer

Overview:
Parametrised successor to the fixed gesture-to-angle mapper. Debounces the finger-count gesture stream and looks up a target pose in a host-writable pose table (NUM_POSES x NUM_SERVOS angles). Slew-limits every servo channel toward that pose at a programmable step rate. Sits between the gesture detector and the per-channel servo PWM generators.

Parameters:
NUM_SERVOS, 4, number of servo channels
ANGLE_W, 8, angle width in bits (degrees)
NUM_POSES, 8, pose table depth; valid gestures are finger_count 0..NUM_POSES-1
MAX_ANGLE, 180, maximum legal angle; table writes clamp to it
STABLE_COUNT, 3, consecutive identical valid samples required to commit a gesture (>=1)
STEP_DIV, 16, clock cycles per 1-degree step during motion (>=1)
TIMEOUT_CYCLES, 1000000, gesture-loss timeout (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
finger_count  in  4  detected finger count
gesture_valid  in  1  finger_count qualifier, one sample per asserted cycle
cfg_we  in  1  pose table write strobe
cfg_pose  in  clog2(NUM_POSES)  table row to write
cfg_servo  in  clog2(NUM_SERVOS)  table column to write
cfg_angle  in  ANGLE_W  angle to write
servo_angle  out  NUM_SERVOS*ANGLE_W  current angles; channel i at [i*ANGLE_W +: ANGLE_W]
target_pose  out  clog2(NUM_POSES)  committed pose index
busy  out  1  high while in MOVE
pose_reached  out  1  one-cycle pulse when all channels reach the target

Behaviour:
- Reset: every table entry = 90; every servo_angle channel = 90; target_pose=0; busy=0; pose_reached=0; candidate=0; stable counter=0; tick counter=0; FSM=IDLE.
- Table write: on a clk edge with cfg_we=1, the entry is written with min(cfg_angle, MAX_ANGLE). Writes with out-of-range cfg_pose or cfg_servo are ignored. A write and a step in the same cycle both take effect; the step uses the old table value.
- Debounce:
  - A sample with gesture_valid=1 and finger_count >= NUM_POSES is ignored; candidate and counter are unchanged.
  - A valid in-range sample equal to candidate increments the counter, saturating at STABLE_COUNT.
  - A valid in-range sample that differs loads candidate and sets the counter to 1.
  - When the counter reaches STABLE_COUNT on an edge, target_pose is loaded with candidate on that same edge. Latency is STABLE_COUNT valid samples; there is no extra pipeline stage.
- FSM IDLE:
  - Each cycle, compare all channels with table[target_pose].
  - Any mismatch: go to MOVE, set busy=1, clear the tick counter.
- FSM MOVE:
  - The tick counter counts 0..STEP_DIV-1 and wraps.
  - On the wrap cycle, each channel moves 1 toward table[target_pose][i]; channels already equal hold.
  - The cycle after all channels match: pose_reached=1 for one cycle, busy=0, return to IDLE.
- Retarget mid-move: a target_pose change or table edit during MOVE is followed immediately from the current angles. The tick counter is not cleared and pose_reached is not pulsed.
- Channels step independently. Angles never go outside 0..MAX_ANGLE and never underflow or overflow ANGLE_W.
- Reset asserted mid-move returns all state to reset values asynchronously.

Optional Feature:
GESTURE_TIMEOUT_EN
- Defined: a counter increments every cycle without gesture_valid and clears on any gesture_valid.
  - On reaching TIMEOUT_CYCLES, target_pose is forced to 0, candidate is cleared and the counter is cleared. Pose 0 is the safe rest pose.
  - The timeout reloads each time it fires.
- Undefined: no counter; target_pose holds indefinitely without gestures.

Test Plan:
- Reset release, no stimulus -> all channels 90, target_pose=0, busy=0, no pose_reached pulse for 100 cycles.
- Write pose2 = {90,120,60,90}; send 3 valid samples of finger_count=2 -> target_pose=2 on the 3rd sample edge. Servo1 reaches 120 after 30 steps (480 cycles at STEP_DIV=16), servo2 reaches 60 after 30 steps. Exactly one pose_reached pulse.
- Samples 2,2,3,2,2,2 -> no commit until the 6th sample; finger_count=9 samples interleaved are ignored and do not reset the count.
- Retarget mid-move: during the pose-2 move, commit pose 5 = {90,135,135,0} -> channels reverse or continue without jumps, step size is exactly 1 per tick, busy stays 1 throughout.
- cfg_angle=200 written to pose1 servo0, then select pose1 -> servo0 stops at 180.
- GESTURE_TIMEOUT_EN with TIMEOUT_CYCLES=50, at pose 2 with no gesture_valid -> target_pose=0 at cycle 50, then motion back to the pose-0 angles.
